// File: rtl/hazard_if.sv
// Hazard-unit bundle: pipeline register indices and controls, cache miss inputs
// and refill status, shared between the pipeline (master) and the hazard controller (slave).
interface hazard_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D;
    logic [REG_ADDR_WIDTH-1:0] Rs2D;
    logic [REG_ADDR_WIDTH-1:0] Rs1E;
    logic [REG_ADDR_WIDTH-1:0] Rs2E;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic [REG_ADDR_WIDTH-1:0] RdM;
    logic [REG_ADDR_WIDTH-1:0] RdW;
    logic                      ResultSrcE0;
    logic                      PCSrcE;
    logic                      RegWriteM;
    logic                      RegWriteW;
    logic                      MissF;
    logic                      MissM;

    logic                      StallF;
    logic                      StallD;
    logic                      StallE;
    logic                      StallM;
    logic                      StallW;
    logic                      FlushD;
    logic                      FlushE;
    logic [1:0]                ForwardAE;
    logic [1:0]                ForwardBE;
    logic                      RefillBusy;
    logic                      RefillSel;
    logic                      RefillDone;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MissF, MissM,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  ForwardAE, ForwardBE, RefillBusy, RefillSel, RefillDone
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MissF, MissM,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output ForwardAE, ForwardBE, RefillBusy, RefillSel, RefillDone
    );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding control for the 5-stage RV32I pipeline, with a refill FSM
// that holds the pipeline for MISS_LATENCY cycles per I- or D-cache refill.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no refill; normal hazard rules, miss detection
//   REFILL_I | I-cache refill; fetch held, bubbles into Decode, D-miss queued
//   REFILL_D | D-cache refill; whole pipeline frozen
module hazard_controller #(
    parameter int MISS_LATENCY   = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic    clk,
    input logic    rst,
    hazard_if.slave hz
);
    localparam int CNT_W = $clog2(MISS_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic LOAD_IS_LAST = (MISS_LATENCY == 1);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL_I = 2'd1,
        REFILL_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_d;
    logic             busy;
    logic             sel;
    logic             done;
    logic             last;

    assign last = (cnt == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pend_d <= 1'b0;
            busy   <= 1'b0;
            sel    <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pend_d <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    if (hz.MissM) begin
                        state <= REFILL_D;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        sel   <= 1'b1;
                        done  <= LOAD_IS_LAST;
                    end else if (hz.MissF) begin
                        state <= REFILL_I;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        sel   <= 1'b0;
                        done  <= LOAD_IS_LAST;
                    end
                end
                REFILL_I: begin
                    if (last) begin
                        // A D-miss that arrived during the I refill is served back to back.
                        if (hz.MissM || pend_d) begin
                            state  <= REFILL_D;
                            cnt    <= CNT_LOAD;
                            sel    <= 1'b1;
                            pend_d <= 1'b0;
                            done   <= LOAD_IS_LAST;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt - CNT_ONE;
                        done <= (cnt == CNT_TWO);
                        if (hz.MissM) pend_d <= 1'b1;
                    end
                end
                REFILL_D: begin
                    if (last) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        cnt  <= cnt - CNT_ONE;
                        done <= (cnt == CNT_TWO);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    pend_d <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    logic lw_stall;
    logic hold_all;
    logic fetch_hold;
    logic [4:0] stall_vec;
    logic flush_d;
    logic flush_e;

    assign lw_stall = hz.ResultSrcE0 && (hz.RdE != REG_ZERO) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_comb begin
        hold_all   = 1'b0;
        fetch_hold = 1'b0;
        case (state)
            IDLE: begin
                hold_all   = hz.MissM;
                fetch_hold = hz.MissF;
            end
            REFILL_I: begin
                hold_all   = hz.MissM || pend_d;
                fetch_hold = 1'b1;
            end
            default: hold_all = 1'b1;
        endcase
    end

    // Stall vector order is {F, D, E, M, W}.
    always_comb begin
        stall_vec = 5'b00000;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        if (hold_all) begin
            stall_vec = 5'b11111;
        end else if (fetch_hold) begin
            stall_vec = {1'b1, lw_stall, 3'b000};
            flush_d   = 1'b1;
            flush_e   = lw_stall || hz.PCSrcE;
        end else begin
            stall_vec = {lw_stall, lw_stall, 3'b000};
            flush_d   = hz.PCSrcE;
            flush_e   = lw_stall || hz.PCSrcE;
        end
    end

    assign hz.StallF = stall_vec[4];
    assign hz.StallD = stall_vec[3];
    assign hz.StallE = stall_vec[2];
    assign hz.StallM = stall_vec[1];
    assign hz.StallW = stall_vec[0];
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;

    // M-stage ALU result has priority over the W result (it is the younger write).
    always_comb begin
        if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == hz.Rs1E))
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == hz.Rs1E))
            hz.ForwardAE = 2'b01;
        else
            hz.ForwardAE = 2'b00;
    end

    always_comb begin
        if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == hz.Rs2E))
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == hz.Rs2E))
            hz.ForwardBE = 2'b01;
        else
            hz.ForwardBE = 2'b00;
    end

    assign hz.RefillBusy = busy;
    assign hz.RefillSel  = sel;
    assign hz.RefillDone = done;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios then random traffic, all checked
// against a cycles-remaining reference model of the refill sequencing.
module tb_hazard_controller;
    localparam int L = 4;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_if #(.REG_ADDR_WIDTH(W)) hz ();

    hazard_controller #(.MISS_LATENCY(L), .REG_ADDR_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: refill cycles left (0 = idle), which cache, queued D-miss.
    int m_left;
    bit m_sel;
    bit m_dq;
    // Cache environment: a cache keeps Miss high until the cycle after its RefillDone.
    bit want_i;
    bit want_d;
    // Observations from the most recent step.
    bit obs_hold_all;
    bit obs_flush;
    bit obs_done;
    bit obs_sel;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [W-1:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step();
        bit lw, busy, done, sel_now, hold, fetch;
        logic [4:0] e_st;
        bit e_fd, e_fe;
        @(negedge clk);
        hz.MissF = want_i;
        hz.MissM = want_d;
        #1;
        lw      = hz.ResultSrcE0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        busy    = (m_left > 0);
        done    = (m_left == 1);
        sel_now = m_sel;
        if (!busy)       hold = hz.MissM;
        else if (m_sel)  hold = 1'b1;
        else             hold = hz.MissM || m_dq;
        fetch = hz.MissF || busy;
        if (hold) begin
            e_st = 5'b11111; e_fd = 1'b0; e_fe = 1'b0;
        end else if (fetch) begin
            e_st = {1'b1, lw, 3'b000}; e_fd = 1'b1; e_fe = lw || hz.PCSrcE;
        end else begin
            e_st = {lw, lw, 3'b000}; e_fd = hz.PCSrcE; e_fe = lw || hz.PCSrcE;
        end
        check_val("stalls", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, e_st);
        check_val("flush_d", hz.FlushD, e_fd);
        check_val("flush_e", hz.FlushE, e_fe);
        check_val("fwd_a", hz.ForwardAE, fwd_ref(hz.Rs1E));
        check_val("fwd_b", hz.ForwardBE, fwd_ref(hz.Rs2E));
        check_val("busy", hz.RefillBusy, busy);
        check_val("done", hz.RefillDone, done);
        if (busy) check_val("sel", hz.RefillSel, m_sel);
        obs_hold_all = hz.StallF & hz.StallD & hz.StallE & hz.StallM & hz.StallW;
        obs_flush    = hz.FlushD | hz.FlushE;
        obs_done     = hz.RefillDone;
        obs_sel      = hz.RefillSel;
        @(posedge clk);
        if (!busy) begin
            if (hz.MissM)      begin m_left = L; m_sel = 1'b1; m_dq = 1'b0; end
            else if (hz.MissF) begin m_left = L; m_sel = 1'b0; m_dq = 1'b0; end
        end else begin
            if (!m_sel && hz.MissM) m_dq = 1'b1;
            if (m_left == 1) begin
                if (!m_sel && m_dq) begin m_left = L; m_sel = 1'b1; m_dq = 1'b0; end
                else m_left = 0;
            end else begin
                m_left--;
            end
        end
        if (done) begin
            if (sel_now) want_d = 1'b0;
            else         want_i = 1'b0;
        end
        #1;
    endtask

    task automatic quiet_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    endtask

    int span, done_at, n_done, flush_in_hold;
    logic [1:0] sels;

    initial begin
        quiet_inputs();
        want_i = 1'b0; want_d = 1'b0;
        hz.MissF = 1'b0; hz.MissM = 1'b0;
        m_left = 0; m_sel = 1'b0; m_dq = 1'b0;
        rst = 1'b1;
        #12;
        check_val("rst_busy", hz.RefillBusy, 1'b0);
        check_val("rst_done", hz.RefillDone, 1'b0);
        check_val("rst_stalls", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, 5'b0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding priority and x0 suppression.
        hz.RdM = 5; hz.RegWriteM = 1'b1; hz.RdW = 5; hz.RegWriteW = 1'b1; hz.Rs1E = 5;
        step();
        check_val("fwd_a_m", hz.ForwardAE, 2'b10);
        hz.RdM = 0;
        step();
        check_val("fwd_a_w", hz.ForwardAE, 2'b01);
        hz.Rs2E = 0; hz.RdW = 0;
        step();
        check_val("fwd_b_x0", hz.ForwardBE, 2'b00);

        // Load-use, then the same with RdE = x0.
        quiet_inputs();
        hz.ResultSrcE0 = 1'b1; hz.RdE = 7; hz.Rs2D = 7;
        step();
        check_val("lw_stall", {hz.StallF, hz.StallD, hz.FlushE}, 3'b111);
        hz.ResultSrcE0 = 1'b0;
        step();
        check_val("lw_gone", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);
        hz.ResultSrcE0 = 1'b1; hz.RdE = 0; hz.Rs2D = 0;
        step();
        check_val("lw_x0", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);

        // Taken branch in IDLE.
        quiet_inputs();
        hz.PCSrcE = 1'b1;
        step();
        check_val("br_flush", {hz.FlushD, hz.FlushE}, 2'b11);

        // D-miss with a concurrent taken branch held until release.
        want_d = 1'b1;
        span = 0; done_at = 0; flush_in_hold = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (obs_hold_all) span++;
            if (obs_hold_all && obs_flush) flush_in_hold++;
            if (obs_done) done_at = i;
        end
        check_val("dmiss_span", span, 5);
        check_val("dmiss_done_cyc", done_at, 5);
        check_val("dmiss_no_flush", flush_in_hold, 0);

        // Simultaneous I and D miss: D first, then I.
        quiet_inputs();
        want_i = 1'b1; want_d = 1'b1;
        n_done = 0; sels = 2'b00;
        for (int i = 0; i < 13; i++) begin
            step();
            if (obs_done) begin
                if (n_done < 2) sels[1 - n_done] = obs_sel;
                n_done++;
            end
        end
        check_val("dual_dones", n_done, 2);
        check_val("dual_order", sels, 2'b10);

        // Reset in the second REFILL_D cycle.
        want_d = 1'b1;
        step();
        step();
        rst = 1'b1; want_d = 1'b0; want_i = 1'b0; hz.MissM = 1'b0; hz.MissF = 1'b0;
        m_left = 0; m_dq = 1'b0;
        #1;
        check_val("arst_busy", hz.RefillBusy, 1'b0);
        check_val("arst_done", hz.RefillDone, 1'b0);
        check_val("arst_stalls", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, 5'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_done) n_done++;
        end
        check_val("arst_no_done", n_done, 0);

        // Random traffic with small register indices to force collisions.
        for (int i = 0; i < 600; i++) begin
            hz.Rs1D = W'($urandom_range(0, 3)); hz.Rs2D = W'($urandom_range(0, 3));
            hz.Rs1E = W'($urandom_range(0, 3)); hz.Rs2E = W'($urandom_range(0, 3));
            hz.RdE  = W'($urandom_range(0, 3)); hz.RdM  = W'($urandom_range(0, 3));
            hz.RdW  = W'($urandom_range(0, 3));
            hz.ResultSrcE0 = ($urandom_range(0, 2) == 0);
            hz.PCSrcE      = ($urandom_range(0, 4) == 0);
            hz.RegWriteM   = $urandom_range(0, 1) != 0;
            hz.RegWriteW   = $urandom_range(0, 1) != 0;
            if (!want_i && $urandom_range(0, 11) == 0) want_i = 1'b1;
            if (!want_d && $urandom_range(0, 13) == 0) want_d = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding muxes.
- Resolves load-use, taken-branch and cache-miss hazards.
- Owns a refill FSM that holds the pipeline for a fixed memory latency while the I-cache or D-cache refills, and arbitrates between the two caches.

Parameters:
- MISS_LATENCY, 4, number of REFILL cycles per cache refill (>=1).
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- Rs1D, Rs2D  input  5  source registers in Decode.
- Rs1E, Rs2E, RdE  input  5  source/destination registers in Execute.
- ResultSrcE0  input  1  Execute instruction is a load.
- PCSrcE  input  1  taken branch/jump resolved in Execute.
- RdM, RdW  input  5  destination registers in Memory/Writeback.
- RegWriteM, RegWriteW  input  1  register write enables in Memory/Writeback.
- MissF  input  1  I-cache miss this cycle.
- MissM  input  1  D-cache miss this cycle.
- StallF, StallD, StallE, StallM, StallW  output  1  hold the PC / stage register.
- FlushD, FlushE  output  1  zero the F/D / D/E register.
- ForwardAE, ForwardBE  output  2  00 = regfile, 01 = W result, 10 = M ALU result.
- RefillBusy  output  1  FSM is in REFILL_I or REFILL_D.
- RefillSel  output  1  0 = I-cache, 1 = D-cache; valid when RefillBusy=1.
- RefillDone  output  1  one-cycle pulse on the last REFILL cycle.

Behaviour:
- FSM states: IDLE, REFILL_I, REFILL_D. Down-counter cnt is $clog2(MISS_LATENCY+1) bits wide.
- Reset (asynchronous, mid-refill included): state=IDLE, cnt=0, RefillBusy=0, RefillDone=0. No RefillDone is issued for an aborted refill. Combinational outputs follow the IDLE equations.
- Forwarding (pure combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE is identical, using Rs2E. The M result has priority over W.
- lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- IDLE transitions:
  - MissM=1 -> REFILL_D, cnt=MISS_LATENCY. MissM wins over a simultaneous MissF because it is the older instruction.
  - Else MissF=1 -> REFILL_I, cnt=MISS_LATENCY.
- IDLE outputs:
  - If MissM=1: StallF/D/E/M/W=1, FlushD=FlushE=0. The stall applies in the detect cycle itself.
  - Else if MissF=1: StallF=1, FlushD=1 (bubble into Decode), and D..W advance. The PCSrcE/lwStall rules below still apply to the later stages, and PCSrcE additionally forces FlushE=1.
  - Else: StallF=StallD=lwStall; FlushD=PCSrcE; FlushE=lwStall|PCSrcE; StallE/M/W=0.
- REFILL_D outputs and transition:
  - All stalls=1; FlushD=FlushE=0. PCSrcE and lwStall are masked; they are re-evaluated after release because E is frozen.
  - cnt decrements each cycle. When cnt==1: RefillDone=1 and next state=IDLE.
- REFILL_I outputs and transition:
  - StallF=1, FlushD=1, with the IDLE rules applied to E..W.
  - A PCSrcE during REFILL_I flushes D/E as normal; the refill still completes.
  - Counter and RefillDone behave as in REFILL_D.
  - A MissM arriving during REFILL_I is stalled (all stalls=1) but queued: after REFILL_I ends, the next state is REFILL_D with no IDLE cycle.
- Stall span per miss: MISS_LATENCY+1 cycles (detect cycle plus the REFILL cycles).
- The caches deassert Miss in the cycle after RefillDone. A Miss still high in IDLE starts a new refill.
- RefillSel is registered on entry to a REFILL state and held until exit.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Set Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Repeat with RdE=0 -> no stall.
- Taken branch: PCSrcE=1 in IDLE -> FlushD=FlushE=1, all stalls 0 that cycle.
- D-miss: MissM=1 for 1 cycle, MISS_LATENCY=4 -> all stalls high for 5 cycles, RefillDone on cycle 5, RefillSel=1. A concurrent PCSrcE produces no flush until release.
- Simultaneous MissF=MissM=1 -> REFILL_D first (4 cycles), then REFILL_I (4 cycles), RefillSel 1 then 0, two RefillDone pulses.
- Assert rst during REFILL_D cycle 2 -> RefillBusy=0 and all stalls 0 immediately, no RefillDone; after release, state is IDLE.
